shift_pipe_norm: RTL and testbench
==================================

// Module: shift_pipe_norm
// PURPOSE
//  Pipelined, parametrised barrel shifter for the FP add/sub datapath. Supports
//  logical left, logical right with sticky, arithmetic right and normalise-left
//  (shift by leading-zero count) modes.
//  Replaces the fixed 24-bit combinational left shifter: used for both exponent
//  alignment (right + sticky) and post-add normalisation (normalise mode).
//  Valid/ready stream interface with full backpressure; a tag passes through
//  aligned with the data.
// PARAMETERS
//  WIDTH  24  data width in bits; WIDTH >= 2
//  SHW    8   shift-amount width; amounts >= WIDTH are legal
//  NSTG   2   pipeline register stages, 1..4; fixed latency = NSTG cycles
//  TAGW   4   sideband tag width, carried unmodified
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           synchronous reset, active-high
//  in_valid   in   1           input beat valid
//  in_ready   out  1           block accepts beat this cycle
//  in_data    in   WIDTH       operand
//  in_shamt   in   SHW         shift amount (ignored in mode 11)
//  in_mode    in   2           00 LSL, 01 LSR, 10 ASR, 11 NORM
//  in_tag     in   TAGW        sideband, returned on out_tag
//  out_valid  out  1           result valid
//  out_ready  in   1           downstream accepts result
//  out_data   out  WIDTH       shifted result
//  out_sticky out  1           OR of all bits shifted out (LSR/ASR); 0 otherwise
//  out_shamt  out  SHW         NORM: leading-zero count applied; else in_shamt echoed
//  out_zero   out  1           in_data was all zeros
//  out_tag    out  TAGW        tag of this result
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): every stage valid bit cleared; out_valid=0.
//    out_data, out_sticky, out_shamt, out_zero and out_tag = 0. rst overrides any
//    handshake in the same cycle, and in-flight beats are discarded.
//  - Pipeline: NSTG register banks, each with a valid bit.
//    The shift levels (16/8/4/2/1, plus saturate) are split evenly across banks,
//    with the remainder going to earlier banks. NORM-mode LZC is computed in stage 1.
//  - Global enable: adv = !out_valid || out_ready; in_ready = adv.
//    Accept when in_valid && in_ready. When adv=0, all banks hold.
//    Result of an accepted beat appears on out_valid exactly NSTG cycles after
//    acceptance if never stalled. Each stall cycle adds exactly one cycle.
//  - Full throughput: one beat per cycle when out_ready is held high. No bubbles
//    are inserted; order is preserved; beats are never dropped or duplicated.
//  - Outputs are stable while out_valid=1 and out_ready=0.
//  - LSL: out = data << shamt, zero fill. shamt >= WIDTH -> out=0. sticky=0.
//  - LSR: out = data >> shamt, zero fill. sticky = |(bits shifted out).
//    shamt >= WIDTH -> out=0, sticky=|data.
//  - ASR: as LSR but fills with data[WIDTH-1]. shamt >= WIDTH -> out = all copies
//    of the sign bit. sticky = |(bits shifted out), i.e. |data for saturation.
//  - NORM: n = leading zeros of data; out = data << n (MSB=1 unless zero);
//    out_shamt = n. data=0 -> out=0, out_shamt=WIDTH, out_zero=1.
//  - shamt=0 in any mode except NORM -> out=data, sticky=0.
//  - out_zero is valid in all modes. out_shamt width is SHW; WIDTH must fit in SHW.
// TESTING (WIDTH=24, SHW=8, NSTG=2, TAGW=4)
//  1. LSL 0x000001 by 23 -> 0x800000. By 24 -> 0x000000. By 255 -> 0x000000.
//     Each result arrives 2 cycles after acceptance.
//  2. LSR 0x800003 by 2 -> 0x200000, sticky=1. ASR 0x800000 by 200 ->
//     0xFFFFFF, sticky=1. ASR 0x400000 by 4 -> 0x040000, sticky=0.
//  3. NORM 0x000300 -> 0xC00000, shamt=14. NORM 0x800000 -> shamt=0.
//     NORM 0x000000 -> data=0, shamt=24, zero=1.
//  4. Stream tags 1..5 back-to-back; out_ready=0 for cycles 3-5.
//     -> All 5 emerged in order; in_ready=0 exactly during the stall.
//     -> Outputs held stable during the stall; no loss.
//  5. Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 on the next
//     cycle; no stale beats emerge; a fresh beat afterwards returns in 2 cycles.
//  6. Random 10k beats across all modes and random out_ready, checked against a
//     reference model for data, sticky, shamt, zero and tag ordering.

Source files
------------

// File: rtl/shift_pipe_norm.sv
// Pipelined barrel shifter for the FP add/sub datapath.
// Modes: 00 LSL, 01 LSR (sticky), 10 ASR (sticky), 11 NORM (shift left by leading-zero count).
// Every mode is executed as a right shift: left-shifting modes bit-reverse the operand on entry
// and reverse the result again before the last bank, so one level structure serves all modes.
// Levels are ordered saturate, 2^(L-1), ..., 1 and split evenly across NSTG banks, with the
// remainder going to the earlier banks. A single global enable stalls all banks together.
module shift_pipe_norm #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned SHW   = 8,
  parameter int unsigned NSTG  = 2,
  parameter int unsigned TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky,
  output logic [SHW-1:0]   out_shamt,
  output logic             out_zero,
  output logic [TAGW-1:0]  out_tag
);

  // Number of power-of-two shift levels; the extra level is saturation.
  localparam int unsigned L    = $clog2(WIDTH);
  localparam int unsigned NLVL = L + 1;
  localparam int unsigned BASE = NLVL / NSTG;
  localparam int unsigned REM  = NLVL % NSTG;

  localparam logic [1:0] ModeLsl  = 2'b00;
  localparam logic [1:0] ModeLsr  = 2'b01;
  localparam logic [1:0] ModeAsr  = 2'b10;
  localparam logic [1:0] ModeNorm = 2'b11;

  // Per-bank pipeline contents.
  // amt   : shift still to be applied (cleared once saturation has been applied)
  // shamt : value reported on out_shamt
  // rev   : operand is bit-reversed (left-shifting modes)
  // fill  : bit shifted in from the top of the (possibly reversed) word
  // stk_en: sticky is reported for this mode
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] data;
    logic             sticky;
    logic [SHW-1:0]   amt;
    logic [SHW-1:0]   shamt;
    logic             zero;
    logic [TAGW-1:0]  tag;
    logic             rev;
    logic             fill;
    logic             stk_en;
  } stage_t;

  stage_t pre;
  stage_t stg_d [NSTG];
  stage_t stg_q [NSTG];
  logic   adv;

  // First level index handled by bank b; earlier banks absorb the remainder.
  function automatic int unsigned first_lvl(int unsigned b);
    return b * BASE + ((b < REM) ? b : REM);
  endfunction

  function automatic logic [WIDTH-1:0] bit_rev(logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      r[i] = x[int'(WIDTH) - 1 - i];
    end
    return r;
  endfunction

  // Leading-zero count; the highest set bit wins because it is visited last.
  function automatic logic [SHW-1:0] lzc(logic [WIDTH-1:0] x);
    logic [SHW-1:0] n;
    n = SHW'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (x[i]) begin
        n = SHW'(int'(WIDTH) - 1 - i);
      end
    end
    return n;
  endfunction

  // One shift level. Level 0 saturates (amount >= WIDTH); level k shifts by 2^(L-k).
  function automatic stage_t apply_lvl(stage_t s, int unsigned lv);
    stage_t             r;
    logic [2*WIDTH-1:0] ext;
    logic [SHW-1:0]     amt_sh;
    logic [WIDTH-1:0]   mask;
    int unsigned        pos;
    int unsigned        sh;
    r = s;
    if (lv == 0) begin
      if (s.amt >= SHW'(WIDTH)) begin
        r.sticky = s.sticky | (|s.data);
        r.data   = {WIDTH{s.fill}};
        r.amt    = '0;
      end
    end else begin
      pos    = L - lv;
      sh     = 32'd1 << pos;
      amt_sh = s.amt >> pos;
      if (amt_sh[0]) begin
        ext      = {{WIDTH{s.fill}}, s.data};
        mask     = ~({WIDTH{1'b1}} << sh);
        r.sticky = s.sticky | (|(s.data & mask));
        r.data   = WIDTH'(ext >> sh);
      end
    end
    return r;
  endfunction

  // All levels owned by bank b; the last bank also undoes the reversal and masks sticky.
  function automatic stage_t run_bank(stage_t s, int unsigned b);
    stage_t r;
    r = s;
    for (int unsigned lv = 0; lv < NLVL; lv++) begin
      if (lv >= first_lvl(b) && lv < first_lvl(b + 1)) begin
        r = apply_lvl(r, lv);
      end
    end
    if (b == NSTG - 1) begin
      if (r.rev) begin
        r.data = bit_rev(r.data);
      end
      r.sticky = r.sticky & r.stk_en;
    end
    return r;
  endfunction

  // Decode the incoming beat into the common right-shift form, including the NORM count.
  always_comb begin
    pre       = '0;
    pre.vld   = in_valid;
    pre.tag   = in_tag;
    pre.zero  = ~|in_data;
    pre.amt   = in_shamt;
    pre.shamt = in_shamt;
    case (in_mode)
      ModeLsl: begin
        pre.data   = bit_rev(in_data);
        pre.rev    = 1'b1;
        pre.fill   = 1'b0;
        pre.stk_en = 1'b0;
      end
      ModeLsr: begin
        pre.data   = in_data;
        pre.rev    = 1'b0;
        pre.fill   = 1'b0;
        pre.stk_en = 1'b1;
      end
      ModeAsr: begin
        pre.data   = in_data;
        pre.rev    = 1'b0;
        pre.fill   = in_data[WIDTH-1];
        pre.stk_en = 1'b1;
      end
      ModeNorm: begin
        pre.data   = bit_rev(in_data);
        pre.rev    = 1'b1;
        pre.fill   = 1'b0;
        pre.stk_en = 1'b0;
        pre.amt    = lzc(in_data);
        pre.shamt  = lzc(in_data);
      end
      default: begin
        pre.data = in_data;
      end
    endcase
  end

  // Next-state for every bank: bank 0 from the decoded input, bank b from bank b-1.
  always_comb begin
    stg_d    = '{default: '0};
    stg_d[0] = run_bank(pre, 0);
    for (int unsigned b = 1; b < NSTG; b++) begin
      stg_d[b] = run_bank(stg_q[b-1], b);
    end
  end

  // Global enable: the whole pipe moves unless the output is held by the consumer.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Pipeline banks; reset discards in-flight beats and zeroes the visible outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned b = 0; b < NSTG; b++) begin
        stg_q[b] <= '0;
      end
    end else if (adv) begin
      for (int unsigned b = 0; b < NSTG; b++) begin
        stg_q[b] <= stg_d[b];
      end
    end
  end

  assign out_valid  = stg_q[NSTG-1].vld;
  assign out_data   = stg_q[NSTG-1].data;
  assign out_sticky = stg_q[NSTG-1].sticky;
  assign out_shamt  = stg_q[NSTG-1].shamt;
  assign out_zero   = stg_q[NSTG-1].zero;
  assign out_tag    = stg_q[NSTG-1].tag;

endmodule

// File: tb/tb_shift_pipe_norm.sv
// Self-checking bench for shift_pipe_norm (WIDTH=24, SHW=8, NSTG=2, TAGW=4).
module tb_shift_pipe_norm;

  localparam int NRAND = 10000;

  typedef struct packed {
    logic [23:0] data;
    logic        sticky;
    logic [7:0]  shamt;
    logic        zero;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic [7:0]  in_shamt;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        out_sticky;
  logic [7:0]  out_shamt;
  logic        out_zero;
  logic [3:0]  out_tag;

  int n_checks;
  int n_fail;

  always #5 clk = ~clk;

  shift_pipe_norm #(
    .WIDTH(24),
    .SHW  (8),
    .NSTG (2),
    .TAGW (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sticky(out_sticky),
    .out_shamt (out_shamt),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  // Reference model written directly from the mode definitions.
  function automatic exp_t model(logic [1:0] m, logic [23:0] d, logic [7:0] sa, logic [3:0] t);
    exp_t e;
    int   n;
    e.tag    = t;
    e.zero   = (d == 24'h0);
    e.shamt  = sa;
    e.sticky = 1'b0;
    e.data   = 24'h0;
    case (m)
      2'b00: e.data = (sa >= 8'd24) ? 24'h0 : (d << sa);
      2'b01: begin
        if (sa >= 8'd24) begin
          e.data = 24'h0;
          e.sticky = |d;
        end else begin
          e.data = d >> sa;
          e.sticky = |(d & ((24'h1 << sa) - 24'h1));
        end
      end
      2'b10: begin
        if (sa >= 8'd24) begin
          e.data = {24{d[23]}};
          e.sticky = |d;
        end else begin
          e.data = $signed(d) >>> sa;
          e.sticky = |(d & ((24'h1 << sa) - 24'h1));
        end
      end
      default: begin
        n = 24;
        for (int i = 0; i < 24; i++) begin
          if (d[i]) n = 23 - i;
        end
        e.shamt = 8'(n);
        e.data  = (d == 24'h0) ? 24'h0 : (d << n);
      end
    endcase
    return e;
  endfunction

  // Send one beat into an empty pipe and capture its result and latency (-1 on timeout).
  task automatic run_one(input logic [1:0] m, input logic [23:0] d, input logic [7:0] sa,
                         input logic [3:0] t, output exp_t r, output int lat);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_mode   = m;
    in_data   = d;
    in_shamt  = sa;
    in_tag    = t;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    r = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        r.data = out_data;
        r.sticky = out_sticky;
        r.shamt = out_shamt;
        r.zero = out_zero;
        r.tag = out_tag;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 24'h0) begin n_fail++; $display("FAIL reset out_data: got %h expected 000000", out_data); end
    n_checks++; if (out_sticky !== 1'b0) begin n_fail++; $display("FAIL reset out_sticky: got %b expected 0", out_sticky); end
    n_checks++; if (out_shamt !== 8'h0) begin n_fail++; $display("FAIL reset out_shamt: got %h expected 00", out_shamt); end
    n_checks++; if (out_zero !== 1'b0) begin n_fail++; $display("FAIL reset out_zero: got %b expected 0", out_zero); end
    n_checks++; if (out_tag !== 4'h0) begin n_fail++; $display("FAIL reset out_tag: got %h expected 0", out_tag); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_lsl();
    exp_t r;
    int   lat;
    run_one(2'b00, 24'h000001, 8'd23, 4'h1, r, lat);
    n_checks++; if (r.data !== 24'h800000) begin n_fail++; $display("FAIL lsl23 data: got %h expected 800000", r.data); end
    n_checks++; if (r.sticky !== 1'b0) begin n_fail++; $display("FAIL lsl23 sticky: got %b expected 0", r.sticky); end
    n_checks++; if (r.tag !== 4'h1) begin n_fail++; $display("FAIL lsl23 tag: got %h expected 1", r.tag); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lsl23 latency: got %0d expected 2", lat); end
    run_one(2'b00, 24'h000001, 8'd24, 4'h2, r, lat);
    n_checks++; if (r.data !== 24'h000000) begin n_fail++; $display("FAIL lsl24 data: got %h expected 000000", r.data); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lsl24 latency: got %0d expected 2", lat); end
    run_one(2'b00, 24'h000001, 8'd255, 4'h3, r, lat);
    n_checks++; if (r.data !== 24'h000000) begin n_fail++; $display("FAIL lsl255 data: got %h expected 000000", r.data); end
    n_checks++; if (r.shamt !== 8'd255) begin n_fail++; $display("FAIL lsl255 shamt: got %h expected ff", r.shamt); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lsl255 latency: got %0d expected 2", lat); end
  endtask

  task automatic test_lsr_asr();
    exp_t r;
    int   lat;
    run_one(2'b01, 24'h800003, 8'd2, 4'h4, r, lat);
    n_checks++; if (r.data !== 24'h200000) begin n_fail++; $display("FAIL lsr2 data: got %h expected 200000", r.data); end
    n_checks++; if (r.sticky !== 1'b1) begin n_fail++; $display("FAIL lsr2 sticky: got %b expected 1", r.sticky); end
    run_one(2'b10, 24'h800000, 8'd200, 4'h5, r, lat);
    n_checks++; if (r.data !== 24'hFFFFFF) begin n_fail++; $display("FAIL asr200 data: got %h expected ffffff", r.data); end
    n_checks++; if (r.sticky !== 1'b1) begin n_fail++; $display("FAIL asr200 sticky: got %b expected 1", r.sticky); end
    run_one(2'b10, 24'h400000, 8'd4, 4'h6, r, lat);
    n_checks++; if (r.data !== 24'h040000) begin n_fail++; $display("FAIL asr4 data: got %h expected 040000", r.data); end
    n_checks++; if (r.sticky !== 1'b0) begin n_fail++; $display("FAIL asr4 sticky: got %b expected 0", r.sticky); end
    run_one(2'b01, 24'hABCDEF, 8'd0, 4'h7, r, lat);
    n_checks++; if (r.data !== 24'hABCDEF) begin n_fail++; $display("FAIL lsr0 data: got %h expected abcdef", r.data); end
    n_checks++; if (r.sticky !== 1'b0) begin n_fail++; $display("FAIL lsr0 sticky: got %b expected 0", r.sticky); end
  endtask

  task automatic test_norm();
    exp_t r;
    int   lat;
    run_one(2'b11, 24'h000300, 8'd0, 4'h8, r, lat);
    n_checks++; if (r.data !== 24'hC00000) begin n_fail++; $display("FAIL norm300 data: got %h expected c00000", r.data); end
    n_checks++; if (r.shamt !== 8'd14) begin n_fail++; $display("FAIL norm300 shamt: got %0d expected 14", r.shamt); end
    n_checks++; if (r.zero !== 1'b0) begin n_fail++; $display("FAIL norm300 zero: got %b expected 0", r.zero); end
    run_one(2'b11, 24'h800000, 8'd7, 4'h9, r, lat);
    n_checks++; if (r.shamt !== 8'd0) begin n_fail++; $display("FAIL norm800000 shamt: got %0d expected 0", r.shamt); end
    n_checks++; if (r.data !== 24'h800000) begin n_fail++; $display("FAIL norm800000 data: got %h expected 800000", r.data); end
    run_one(2'b11, 24'h000000, 8'd3, 4'hA, r, lat);
    n_checks++; if (r.data !== 24'h0) begin n_fail++; $display("FAIL norm0 data: got %h expected 000000", r.data); end
    n_checks++; if (r.shamt !== 8'd24) begin n_fail++; $display("FAIL norm0 shamt: got %0d expected 24", r.shamt); end
    n_checks++; if (r.zero !== 1'b1) begin n_fail++; $display("FAIL norm0 zero: got %b expected 1", r.zero); end
  endtask

  // Tags 1..5 as LSL of 1 by the tag; consumer stalls in cycles 3-5.
  task automatic test_back_to_back();
    int   nxt_in;
    int   nxt_out;
    logic exp_rdy;
    nxt_in  = 1;
    nxt_out = 1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      in_valid  = (nxt_in <= 5);
      in_mode   = 2'b00;
      in_data   = 24'h000001;
      in_shamt  = 8'(nxt_in);
      in_tag    = 4'(nxt_in);
      out_ready = !(c >= 3 && c <= 5);
      @(negedge clk);
      exp_rdy = !(c >= 3 && c <= 5);
      if (c <= 8) begin
        n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b in_ready cycle %0d: got %b expected %b", c, in_ready, exp_rdy); end
      end
      if (c >= 3 && c <= 5) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b stall valid cycle %0d: got %b expected 1", c, out_valid); end
        n_checks++; if (out_tag !== 4'h1) begin n_fail++; $display("FAIL b2b stall tag cycle %0d: got %h expected 1", c, out_tag); end
        n_checks++; if (out_data !== 24'h000002) begin n_fail++; $display("FAIL b2b stall data cycle %0d: got %h expected 000002", c, out_data); end
      end
      if (out_valid && out_ready) begin
        n_checks++; if (out_tag !== 4'(nxt_out)) begin n_fail++; $display("FAIL b2b order: got tag %h expected %h", out_tag, 4'(nxt_out)); end
        n_checks++; if (out_data !== (24'h1 << nxt_out)) begin n_fail++; $display("FAIL b2b data: got %h expected %h", out_data, 24'h1 << nxt_out); end
        nxt_out++;
      end
      if (in_valid && in_ready) nxt_in++;
    end
    n_checks++; if (nxt_out !== 6) begin n_fail++; $display("FAIL b2b count: got %0d results expected 5", nxt_out - 1); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset_inflight();
    exp_t r;
    int   lat;
    int   stale;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    in_data   = 24'h000001;
    in_shamt  = 8'd3;
    in_tag    = 4'h9;
    @(posedge clk); #1;
    in_tag    = 4'hA;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstfl before: got out_valid %b expected 1", out_valid); end
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstfl out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_tag !== 4'h0) begin n_fail++; $display("FAIL rstfl out_tag: got %h expected 0", out_tag); end
    n_checks++; if (out_data !== 24'h0) begin n_fail++; $display("FAIL rstfl out_data: got %h expected 000000", out_data); end
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL rstfl stale beats: got %0d expected 0", stale); end
    run_one(2'b01, 24'h00F000, 8'd12, 4'hB, r, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rstfl fresh latency: got %0d expected 2", lat); end
    n_checks++; if (r.data !== 24'h00000F) begin n_fail++; $display("FAIL rstfl fresh data: got %h expected 00000f", r.data); end
    n_checks++; if (r.tag !== 4'hB) begin n_fail++; $display("FAIL rstfl fresh tag: got %h expected b", r.tag); end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int   sent;
    int   got;
    int   cyc;
    int   k;
    logic acc;
    sent = 0;
    got  = 0;
    cyc  = 0;
    acc  = 1'b0;
    in_valid = 1'b0;
    while (got < NRAND && cyc < 80000) begin
      @(posedge clk); #1;
      cyc++;
      if (!in_valid || acc) begin
        in_valid = (sent < NRAND) && ($urandom_range(0, 4) != 0);
        in_mode  = 2'($urandom_range(0, 3));
        in_tag   = 4'($urandom);
        in_data  = 24'($urandom);
        k = $urandom_range(0, 9);
        if (k == 0) in_data = 24'h0;
        else if (k < 5) in_data = in_data >> $urandom_range(0, 24);
        k = $urandom_range(0, 9);
        if (k < 6) in_shamt = 8'($urandom_range(0, 23));
        else if (k < 8) in_shamt = 8'($urandom_range(24, 31));
        else in_shamt = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back(model(in_mode, in_data, in_shamt, in_tag));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rand spurious: got tag %h with no beat outstanding, expected none", out_tag);
        end else begin
          e = q.pop_front();
          n_checks++; if (out_data !== e.data) begin n_fail++; $display("FAIL rand data #%0d: got %h expected %h", got, out_data, e.data); end
          n_checks++; if (out_sticky !== e.sticky) begin n_fail++; $display("FAIL rand sticky #%0d: got %b expected %b", got, out_sticky, e.sticky); end
          n_checks++; if (out_shamt !== e.shamt) begin n_fail++; $display("FAIL rand shamt #%0d: got %h expected %h", got, out_shamt, e.shamt); end
          n_checks++; if (out_zero !== e.zero) begin n_fail++; $display("FAIL rand zero #%0d: got %b expected %b", got, out_zero, e.zero); end
          n_checks++; if (out_tag !== e.tag) begin n_fail++; $display("FAIL rand tag #%0d: got %h expected %h", got, out_tag, e.tag); end
        end
        got++;
      end
    end
    n_checks++; if (got !== NRAND) begin n_fail++; $display("FAIL rand completion: got %0d results expected %0d", got, NRAND); end
    n_checks++; if (q.size() !== 0) begin n_fail++; $display("FAIL rand leftover: got %0d outstanding expected 0", q.size()); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 24'h0;
    in_shamt  = 8'h0;
    in_mode   = 2'b00;
    in_tag    = 4'h0;
    out_ready = 1'b0;
    test_reset();
    test_lsl();
    test_lsr_asr();
    test_norm();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
